// File: rtl/dmem_wait_responder_if.sv
// Store/load bus between the core (master) and the data-memory responder (slave).
interface dmem_wait_responder_if;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Ready;

  modport master (output MemWrite, MemRead, DataAdr, WriteData,
                  input  ReadData, Ready);
  modport slave  (input  MemWrite, MemRead, DataAdr, WriteData,
                  output ReadData, Ready);
endinterface

// File: rtl/dmem_wait_responder.sv
// Data-memory responder with fixed wait states and a sticky result-store monitor.
// Define DMEM_BOUNDS_EN to add AddrErr and reject accesses outside the array.
//
// state | meaning
// IDLE  | waiting for MemWrite/MemRead; request registers load on the accepting edge
// BUSY  | counting down wait states on the latched request
// DONE  | Ready pulse; write committed or ReadData loaded on the entering edge
module dmem_wait_responder #(
  parameter int unsigned ADDR_BITS   = 6,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] RESULT_ADDR = 32'h0000_0064
) (
  input  logic                        clk,
  input  logic                        reset,
  dmem_wait_responder_if.slave        bus,
  output logic                        ResultHit,
  output logic [31:0]                 ResultValue
`ifdef DMEM_BOUNDS_EN
  ,
  output logic                        AddrErr
`endif
);

  localparam int unsigned DEPTH     = 2 ** ADDR_BITS;
  localparam logic [3:0]  WAIT_LD   = 4'(WAIT_CYCLES);
  localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] adr_q;
  logic [31:0] data_q;
  logic        we_q;
  logic        ready_q;
  logic [31:0] rdata_q;
  logic        hit_q;
  logic [31:0] value_q;
  logic        err_q;

  logic [31:0] mem_q [0:DEPTH-1];

  logic                 req;
  logic                 commit;
  logic                 c_we;
  logic                 c_err;
  logic [31:0]          c_adr;
  logic [31:0]          c_data;
  logic [ADDR_BITS-1:0] c_idx;

  // With zero wait states the commit happens on the accepting edge, so it
  // must use the live bus values rather than the request registers.
  always_comb begin
    req    = bus.MemWrite | bus.MemRead;
    c_adr  = adr_q;
    c_data = data_q;
    c_we   = we_q;
    if (state_q == IDLE) begin
      c_adr  = bus.DataAdr;
      c_data = bus.WriteData;
      c_we   = bus.MemWrite;
    end
    commit = reset &&
             (((state_q == IDLE) && req && ZERO_WAIT) ||
              ((state_q == BUSY) && (cnt_q == 4'd1)));
    c_idx  = c_adr[ADDR_BITS+1:2];
`ifdef DMEM_BOUNDS_EN
    c_err  = |c_adr[31:ADDR_BITS+2];
`else
    c_err  = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= 32'd0;
      data_q  <= 32'd0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= 32'd0;
      hit_q   <= 1'b0;
      value_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            adr_q  <= bus.DataAdr;
            data_q <= bus.WriteData;
            we_q   <= bus.MemWrite;
            if (ZERO_WAIT) begin
              state_q <= DONE;
            end else begin
              cnt_q   <= WAIT_LD;
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (commit) begin
        ready_q <= 1'b1;
        err_q   <= c_err;
        if (c_we) begin
          if (c_adr == RESULT_ADDR) begin
            hit_q   <= 1'b1;
            value_q <= c_data;
          end
        end else begin
          rdata_q <= c_err ? 32'hDEAD_BEEF : mem_q[c_idx];
        end
      end
    end
  end

  // Array is deliberately left out of reset so contents survive an abort.
  always_ff @(posedge clk) begin
    if (commit && c_we && !c_err) mem_q[c_idx] <= c_data;
  end

  assign bus.Ready    = ready_q;
  assign bus.ReadData = rdata_q;
  assign ResultHit    = hit_q;
  assign ResultValue  = value_q;
`ifdef DMEM_BOUNDS_EN
  assign AddrErr      = err_q;
`endif

endmodule
